// File: rtl/slave_mem_pkg.sv
// Shared types and default constants for the slave memory block.
package slave_mem_pkg;

    localparam int DEF_DW       = 32;
    localparam int DEF_ACK_WAIT = 1;
    localparam int DEF_RD_LAT   = 2;

    // Wait counter width: covers ACK_WAIT 0..15 and RD_LAT-1 0..14.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACK_DLY,
        RD_DLY
    } state_t;

endpackage

// File: rtl/slave_mem_array.sv
// Single-port storage: synchronous write, registered read on the same index.
module slave_mem_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write when enabled; always read the addressed word (old data on a write).
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        rdata <= mem[idx];
    end

endmodule

// File: rtl/slave_mem.sv
// Crossbar slave memory: one outstanding transaction, programmable ack and
// read-response latency, out-of-range accesses counted and answered with zero.
module slave_mem
    import slave_mem_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = 30,
    parameter int DEPTH    = 256,
    parameter int ACK_WAIT = DEF_ACK_WAIT,
    parameter int RD_LAT   = DEF_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          cmd,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic          resp,
    output logic [DW-1:0] rdata,
    output logic [15:0]   err_cnt
);

    localparam int IW = $clog2(DEPTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ack_nxt, resp_nxt, capture;
    logic             cmd_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q, rd_q, rd_buf, sample;
    logic [IW-1:0]    idx;
    logic             in_range, we;

    // Upper address bits beyond the storage index must all be zero.
    assign in_range = ((addr_q >> IW) == '0);
    // In IDLE the live address is presented so the read is ready by the ack
    // cycle even with zero wait states.
    assign idx      = (state == IDLE) ? addr[IW-1:0] : addr_q[IW-1:0];
    assign we       = ack && cmd_q && in_range && !rst;
    assign sample   = in_range ? rd_q : '0;

    slave_mem_array #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_array (
        .clk   (clk),
        .we    (we),
        .idx   (idx),
        .wdata (wdata_q),
        .rdata (rd_q)
    );

    // State and pulse registers; ack/resp are set one edge ahead so they
    // appear exactly on the cycle the counter reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ack   <= 1'b0;
            resp  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack   <= ack_nxt;
            resp  <= resp_nxt;
        end
    end

    // Next-state, counter and pulse decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = 1'b0;
        resp_nxt  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture   = 1'b1;
                    state_nxt = ACK_DLY;
                    cnt_nxt   = CNT_W'(ACK_WAIT);
                    ack_nxt   = (ACK_WAIT == 0);
                end
            end
            ACK_DLY: begin
                if (ack) begin
                    if (cmd_q) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RD_DLY;
                        cnt_nxt   = CNT_W'(RD_LAT - 1);
                        resp_nxt  = (RD_LAT == 1);
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    ack_nxt = (cnt == CNT_W'(1));
                end
            end
            RD_DLY: begin
                if (resp) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt  = cnt - CNT_W'(1);
                    resp_nxt = (cnt == CNT_W'(1));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and read-data hold between the ack and resp cycles.
    always_ff @(posedge clk) begin
        if (capture) begin
            cmd_q   <= cmd;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
        if (ack && !cmd_q) rd_buf <= sample;
    end

    // Read data output and saturating out-of-range counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata   <= '0;
            err_cnt <= '0;
        end else begin
            if (resp_nxt) rdata <= (state == ACK_DLY) ? sample : rd_buf;
            if (ack && !in_range && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_slave_mem.sv
// Scoreboard bench: instance A (ACK_WAIT=1, RD_LAT=2, DEPTH=256) and
// instance B (ACK_WAIT=0, RD_LAT=1, DEPTH=16).
module tb_slave_mem;

    logic        clk = 1'b0;
    int          cyc = 0;

    logic        rst_a, req_a, cmd_a, ack_a, resp_a;
    logic [29:0] addr_a;
    logic [31:0] wdata_a, rdata_a;
    logic [15:0] err_a;

    logic        rst_b, req_b, cmd_b, ack_b, resp_b;
    logic [29:0] addr_b;
    logic [31:0] wdata_b, rdata_b;
    logic [15:0] err_b;

    typedef struct {
        bit          is_resp;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        qa[$], qb[$];
    logic [31:0] model_a [256];
    logic [31:0] model_b [16];
    int          n_pass = 0, n_tot = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    slave_mem #(.DW(32), .AW(30), .DEPTH(256), .ACK_WAIT(1), .RD_LAT(2)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .cmd(cmd_a), .addr(addr_a), .wdata(wdata_a),
        .ack(ack_a), .resp(resp_a), .rdata(rdata_a), .err_cnt(err_a)
    );

    slave_mem #(.DW(32), .AW(30), .DEPTH(16), .ACK_WAIT(0), .RD_LAT(1)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .cmd(cmd_b), .addr(addr_b), .wdata(wdata_b),
        .ack(ack_b), .resp(resp_b), .rdata(rdata_b), .err_cnt(err_b)
    );

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: every ack/resp pops the next expected event for that instance.
    task automatic mon(bit sel);
        logic        a, r;
        logic [31:0] d;
        exp_t        e;
        int          n;
        a = sel ? ack_b : ack_a;
        r = sel ? resp_b : resp_a;
        d = sel ? rdata_b : rdata_a;
        if (!(a || r)) return;
        check(sel ? "b_ack_resp_excl" : "a_ack_resp_excl", a & r, 0);
        n = sel ? qb.size() : qa.size();
        if (n == 0) begin
            check(sel ? "b_unexpected_output" : "a_unexpected_output", {a, r}, 0);
            return;
        end
        if (sel) e = qb.pop_front(); else e = qa.pop_front();
        check(sel ? "b_kind" : "a_kind", r, e.is_resp);
        check(sel ? "b_cycle" : "a_cycle", cyc, e.cyc);
        if (r) check(sel ? "b_rdata" : "a_rdata", d, e.data);
    endtask

    always @(posedge clk) begin
        #1;
        mon(1'b0);
        mon(1'b1);
    end

    task automatic push(bit sel, bit is_resp, int c, logic [31:0] d);
        exp_t e;
        e.is_resp = is_resp;
        e.cyc     = c;
        e.data    = d;
        if (sel) qb.push_back(e); else qa.push_back(e);
    endtask

    // One-cycle req pulse; the expected ack (and resp) cycles are queued.
    task automatic issue(bit sel, bit c, logic [29:0] a, logic [31:0] d, logic [31:0] er, bit want_resp);
        int aw, rl;
        aw = sel ? 0 : 1;
        rl = sel ? 1 : 2;
        @(negedge clk);
        if (sel) begin req_b = 1; cmd_b = c; addr_b = a; wdata_b = d; end
        else     begin req_a = 1; cmd_a = c; addr_a = a; wdata_a = d; end
        push(sel, 1'b0, cyc + aw + 1, '0);
        if (!c && want_resp) push(sel, 1'b1, cyc + aw + 1 + rl, er);
        @(negedge clk);
        req_a = 0;
        req_b = 0;
    endtask

    task automatic drain(bit sel);
        int n;
        for (int i = 0; i < 40; i++) begin
            n = sel ? qb.size() : qa.size();
            if (n == 0) break;
            @(negedge clk);
        end
        n = sel ? qb.size() : qa.size();
        check(sel ? "b_drain_timeout" : "a_drain_timeout", n, 0);
        if (n != 0) begin
            if (sel) qb.delete(); else qa.delete();
        end
    endtask

    task automatic op(bit sel, bit c, logic [29:0] a, logic [31:0] d);
        logic [31:0] er;
        bit          inr;
        er  = '0;
        inr = sel ? (a < 16) : (a < 256);
        if (!c && inr) er = sel ? model_b[a[3:0]] : model_a[a[7:0]];
        issue(sel, c, a, d, er, 1'b1);
        if (c && inr) begin
            if (sel) model_b[a[3:0]] = d; else model_a[a[7:0]] = d;
        end
        drain(sel);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [29:0] ra;
        logic [31:0] rd;
        bit          rc;

        rst_a = 1; rst_b = 1;
        req_a = 0; cmd_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; cmd_b = 0; addr_b = '0; wdata_b = '0;
        repeat (3) @(negedge clk);
        rst_a = 0; rst_b = 0;
        check("reset_ack", {ack_a, ack_b}, 0);
        check("reset_resp", {resp_a, resp_b}, 0);
        check("reset_rdata", {rdata_a, rdata_b}, 0);
        check("reset_err", {err_a, err_b}, 0);

        // Basic write then read-back.
        op(0, 1, 30'd3, 32'h0000_00A5);
        op(0, 0, 30'd3, '0);

        // Out-of-range read/write; word 0 must survive the aliased write.
        op(0, 1, 30'd0, 32'h1234_5678);
        op(0, 0, 30'h100, '0);
        @(negedge clk);
        check("err_after_oor_read", err_a, 16'd1);
        op(0, 1, 30'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        check("err_after_oor_write", err_a, 16'd2);
        op(0, 0, 30'd0, '0);

        // Reset during RD_DLY: the ack is seen, the resp must never come.
        issue(0, 0, 30'd3, 32'h0, 32'h0, 1'b0);
        @(negedge clk);            // ack cycle
        @(negedge clk); rst_a = 1; // RD_DLY
        @(negedge clk); rst_a = 0;
        repeat (20) @(negedge clk);
        check("abort_queue_empty", qa.size(), 0);
        check("abort_err_cleared", err_a, 0);
        check("abort_rdata_cleared", rdata_a, 0);
        op(0, 0, 30'd3, '0);

        // Write whose ack cycle coincides with reset is dropped.
        op(0, 1, 30'd5, 32'h0000_0011);
        issue(0, 1, 30'd5, 32'h0000_0022, 32'h0, 1'b0);
        @(negedge clk); rst_a = 1; // ack cycle
        @(negedge clk); rst_a = 0;
        drain(0);
        op(0, 0, 30'd5, '0);

        // Saturation of the error counter from a forced starting value.
        @(negedge clk);
        force dut_a.err_cnt = 16'hFFFC;
        @(negedge clk);
        release dut_a.err_cnt;
        op(0, 1, 30'h200, 32'h1);
        op(0, 1, 30'h3FFF_FFFF, 32'h2);
        op(0, 1, 30'h100, 32'h3);
        @(negedge clk);
        check("err_reaches_ffff", err_a, 16'hFFFF);
        op(0, 0, 30'h1000, '0);
        op(0, 1, 30'h101, 32'h4);
        @(negedge clk);
        check("err_saturated", err_a, 16'hFFFF);

        // Back-to-back random in-range traffic against the model.
        for (int i = 0; i < 8; i++) op(0, 1, 30'(i), 32'hC0DE_0000 + 32'(i));
        for (int i = 0; i < 16; i++) begin
            rc = 1'($urandom_range(0, 1));
            ra = 30'($urandom_range(0, 7));
            rd = $urandom;
            op(0, rc, ra, rd);
        end

        // Zero wait states: ack next cycle, overlapping req ignored.
        op(1, 1, 30'd4, 32'h0000_0055);
        @(negedge clk);
        req_b = 1; cmd_b = 1; addr_b = 30'd2; wdata_b = 32'h0000_0077;
        push(1, 1'b0, cyc + 1, '0);
        model_b[2] = 32'h0000_0077;
        @(negedge clk);
        addr_b = 30'd4; wdata_b = 32'h0000_0099;
        @(negedge clk);
        req_b = 0;
        drain(1);
        op(1, 0, 30'd4, '0);
        op(1, 0, 30'd2, '0);
        op(1, 0, 30'd16, '0);
        @(negedge clk);
        check("b_err_oor", err_b, 16'd1);

        repeat (5) @(negedge clk);
        check("final_a_queue_empty", qa.size(), 0);
        check("final_b_queue_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
